// File: rtl/ssm_decap.sv
// ssm_decap - receive side of the statistic sampling (SSM) link.
//
// Strips the one-line SSM metadata header from each encapsulated packet,
// re-marks the head/body/tail flags on the remaining lines and forwards the
// original packet together with its valid word. The metadata timestamp and
// sequence number are presented on meta_ts/meta_seq when a good packet's
// valid is forwarded. Packet, runt, protocol-error and sequence-gap
// statistics are kept for the host.
//
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   pktin_data[133:0]      [133:132] 01 head / 11 body / 10 tail,
//                          [131:128] invalid byte count, [127:0] data
//   pktin_data_wr          input line strobe
//   pktin_data_valid(_wr)  per-packet keep/discard word and its strobe
//   cnt_rst                synchronous clear of the statistic counters
//   pktout_data(_wr)       decapsulated line and strobe (same format)
//   pktout_data_valid(_wr) forwarded or generated valid and its strobe
//   meta_ts, meta_seq      metadata of the last good packet
//   meta_wr                pulses with a forwarded valid of 1
//   pkt_num, runt_num,     good packets, dropped runts, protocol errors,
//   err_num, gap_num       summed missing sequence numbers (all saturating)
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a packet head (metadata line)
//   META  | metadata captured, waiting for the first payload line
//   DATA  | one payload line sits in the hold register
//   FLUSH | the tail is in the hold register and leaves this cycle

module ssm_decap #(
  parameter int MIN_LINES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] pktin_data,
  input  logic         pktin_data_wr,
  input  logic         pktin_data_valid,
  input  logic         pktin_data_valid_wr,
  input  logic         cnt_rst,
  output logic [133:0] pktout_data,
  output logic         pktout_data_wr,
  output logic         pktout_data_valid,
  output logic         pktout_data_valid_wr,
  output logic [47:0]  meta_ts,
  output logic [31:0]  meta_seq,
  output logic         meta_wr,
  output logic [31:0]  pkt_num,
  output logic [15:0]  runt_num,
  output logic [15:0]  err_num,
  output logic [31:0]  gap_num
);

  localparam logic [1:0] FLAG_HEAD = 2'b01;
  localparam logic [1:0] FLAG_BODY = 2'b11;
  localparam logic [1:0] FLAG_TAIL = 2'b10;

  typedef enum logic [1:0] {IDLE, META, DATA, FLUSH} state_t;

  state_t state, state_nxt;

  logic         in_head, in_tail;
  logic [133:0] hold_line;
  logic [15:0]  line_cnt;
  logic [47:0]  cur_ts;
  logic [31:0]  cur_seq;
  logic         short_pkt;

  logic         cap_meta, hold_ld, emit, gen_abort;
  logic         runt_ev, err_ev, push_ev, push_runt;
  logic [1:0]   hold_flag, emit_flag;

  // Packets whose tail has been accepted but whose upstream valid has not
  // arrived yet. Valids arrive in packet order, so the oldest entry owns the
  // next incoming valid strobe; runt entries simply swallow it.
  logic [1:0]   fifo_cnt;
  logic         fifo_rp, fifo_wp;
  logic         fifo_runt [2];
  logic [47:0]  fifo_ts   [2];
  logic [31:0]  fifo_seq  [2];
  logic         pop, bypass, do_push, pend_set;

  logic         pend_vld, pend_val;
  logic [47:0]  pend_ts;
  logic [31:0]  pend_seq;
  logic         fire, good;

  logic         exp_vld;
  logic [31:0]  exp_seq;
  logic [31:0]  gap_diff;
  logic [32:0]  gap_sum;
  logic         gap_hit;

  assign in_head   = pktin_data_wr && (pktin_data[133:132] == FLAG_HEAD);
  assign in_tail   = pktin_data_wr && (pktin_data[133:132] == FLAG_TAIL);
  assign short_pkt = (int'(line_cnt) + 1) < MIN_LINES;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_meta  = 1'b0;
    hold_ld   = 1'b0;
    hold_flag = FLAG_BODY;
    emit      = 1'b0;
    emit_flag = hold_line[133:132];
    gen_abort = 1'b0;
    runt_ev   = 1'b0;
    err_ev    = 1'b0;
    push_ev   = 1'b0;
    push_runt = 1'b0;
    case (state)
      IDLE: begin
        if (in_head) begin
          cap_meta  = 1'b1;
          state_nxt = META;
        end else if (pktin_data_wr) begin
          err_ev = 1'b1;
        end
      end
      META: begin
        if (in_tail) begin
          runt_ev   = 1'b1;
          push_ev   = 1'b1;
          push_runt = 1'b1;
          state_nxt = IDLE;
        end else if (in_head) begin
          err_ev   = 1'b1;
          cap_meta = 1'b1;
        end else if (pktin_data_wr) begin
          hold_ld   = 1'b1;
          hold_flag = FLAG_HEAD;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (in_head) begin
          // missing tail: close the packet on the held line and discard it
          emit      = 1'b1;
          emit_flag = FLAG_TAIL;
          gen_abort = 1'b1;
          err_ev    = 1'b1;
          cap_meta  = 1'b1;
          state_nxt = META;
        end else if (in_tail) begin
          if (short_pkt) begin
            runt_ev   = 1'b1;
            push_ev   = 1'b1;
            push_runt = 1'b1;
            state_nxt = IDLE;
          end else begin
            emit      = 1'b1;
            hold_ld   = 1'b1;
            hold_flag = FLAG_TAIL;
            push_ev   = 1'b1;
            state_nxt = FLUSH;
          end
        end else if (pktin_data_wr) begin
          emit    = 1'b1;
          hold_ld = 1'b1;
        end
      end
      FLUSH: begin
        emit = 1'b1;
        if (in_head) begin
          cap_meta  = 1'b1;
          state_nxt = META;
        end else begin
          err_ev    = pktin_data_wr;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_line <= '0;
      line_cnt  <= '0;
      cur_ts    <= '0;
      cur_seq   <= '0;
    end else begin
      if (cap_meta) begin
        cur_ts  <= pktin_data[127:80];
        cur_seq <= pktin_data[79:48];
      end
      if (hold_ld) begin
        hold_line <= {hold_flag, pktin_data[131:0]};
        if (hold_flag == FLAG_HEAD)  line_cnt <= 16'd1;
        else if (line_cnt != '1)     line_cnt <= line_cnt + 16'd1;
      end
    end
  end

  assign pop      = pktin_data_valid_wr && (fifo_cnt != 2'd0);
  // valid strobe in the same cycle as the tail, nothing older outstanding
  assign bypass   = pktin_data_valid_wr && (fifo_cnt == 2'd0) && push_ev;
  assign do_push  = push_ev && !bypass && ((fifo_cnt != 2'd2) || pop);
  assign pend_set = (pop && !fifo_runt[fifo_rp]) || (bypass && !push_runt);

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt <= '0;
      fifo_rp  <= 1'b0;
      fifo_wp  <= 1'b0;
    end else begin
      if (do_push) fifo_wp <= ~fifo_wp;
      if (pop)     fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, do_push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_runt[fifo_wp] <= push_runt;
      fifo_ts[fifo_wp]   <= cur_ts;
      fifo_seq[fifo_wp]  <= cur_seq;
    end
  end

  // A pending valid always belongs to a packet whose tail is already in the
  // output register or being loaded into it, so it may fire at once. An
  // abort-generated valid owns the strobe; the pending one waits a cycle.
  assign fire = pend_vld && !gen_abort;
  assign good = fire && pend_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_val <= 1'b0;
      pend_ts  <= '0;
      pend_seq <= '0;
    end else if (pend_set) begin
      pend_vld <= 1'b1;
      pend_val <= pktin_data_valid;
      pend_ts  <= pop ? fifo_ts[fifo_rp]  : cur_ts;
      pend_seq <= pop ? fifo_seq[fifo_rp] : cur_seq;
    end else if (fire) begin
      pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pktout_data          <= '0;
      pktout_data_wr       <= 1'b0;
      pktout_data_valid    <= 1'b0;
      pktout_data_valid_wr <= 1'b0;
      meta_ts              <= '0;
      meta_seq             <= '0;
      meta_wr              <= 1'b0;
    end else begin
      pktout_data_wr       <= emit;
      pktout_data_valid_wr <= gen_abort || fire;
      pktout_data_valid    <= good;
      meta_wr              <= good;
      if (emit) pktout_data <= {emit_flag, hold_line[131:0]};
      if (good) begin
        meta_ts  <= pend_ts;
        meta_seq <= pend_seq;
      end
    end
  end

  assign gap_diff = pend_seq - exp_seq;
  assign gap_sum  = {1'b0, gap_num} + {1'b0, gap_diff};
  assign gap_hit  = good && exp_vld && (pend_seq > exp_seq);

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_vld <= 1'b0;
      exp_seq <= '0;
    end else if (good) begin
      exp_vld <= 1'b1;
      exp_seq <= pend_seq + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_rst) begin
      pkt_num  <= '0;
      runt_num <= '0;
      err_num  <= '0;
      gap_num  <= '0;
    end else begin
      if (good && (pkt_num != '1))     pkt_num  <= pkt_num + 32'd1;
      if (runt_ev && (runt_num != '1)) runt_num <= runt_num + 16'd1;
      if (err_ev && (err_num != '1))   err_num  <= err_num + 16'd1;
      if (gap_hit)                     gap_num  <= gap_sum[32] ? '1 : gap_sum[31:0];
    end
  end

endmodule

// File: tb/tb_ssm_decap.sv
// Bench for ssm_decap: a packet table with cumulative counter expectations,
// hand-written abort / counter-clear / back-to-back / reset sequences, and a
// line + valid scoreboard fed by the drivers and drained by a monitor.
module tb_ssm_decap;
  localparam int MIN_LINES = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [133:0] pktin_data;
  logic         pktin_data_wr;
  logic         pktin_data_valid;
  logic         pktin_data_valid_wr;
  logic         cnt_rst;
  logic [133:0] pktout_data;
  logic         pktout_data_wr;
  logic         pktout_data_valid;
  logic         pktout_data_valid_wr;
  logic [47:0]  meta_ts;
  logic [31:0]  meta_seq;
  logic         meta_wr;
  logic [31:0]  pkt_num;
  logic [15:0]  runt_num;
  logic [15:0]  err_num;
  logic [31:0]  gap_num;

  always #5 clk = ~clk;

  ssm_decap #(.MIN_LINES(MIN_LINES)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pktin_data           (pktin_data),
    .pktin_data_wr        (pktin_data_wr),
    .pktin_data_valid     (pktin_data_valid),
    .pktin_data_valid_wr  (pktin_data_valid_wr),
    .cnt_rst              (cnt_rst),
    .pktout_data          (pktout_data),
    .pktout_data_wr       (pktout_data_wr),
    .pktout_data_valid    (pktout_data_valid),
    .pktout_data_valid_wr (pktout_data_valid_wr),
    .meta_ts              (meta_ts),
    .meta_seq             (meta_seq),
    .meta_wr              (meta_wr),
    .pkt_num              (pkt_num),
    .runt_num             (runt_num),
    .err_num              (err_num),
    .gap_num              (gap_num)
  );

  typedef struct packed {
    logic        valid;
    logic        mwr;
    logic [47:0] ts;
    logic [31:0] seq;
  } vexp_t;

  typedef struct {
    logic [31:0] seq;
    int          n;
    logic [3:0]  bc;
    logic        v;
    int          vdelay;
    logic [31:0] e_pkt;
    logic [15:0] e_runt;
    logic [31:0] e_gap;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [133:0] exp_lines[$];
  vexp_t        exp_valids[$];
  int tails_seen  = 0;
  int valids_seen = 0;
  logic [133:0] mon_line;
  vexp_t        mon_v;
  vec_t         tbl[9];

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, {102'd0, act}, {102'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pktin_data_wr       = 1'b0;
    pktin_data_valid_wr = 1'b0;
    repeat (n) tick();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_line(input logic [1:0] flag, input logic [3:0] bc, input logic [127:0] d,
                            input logic vwr, input logic v);
    pktin_data          = {flag, bc, d};
    pktin_data_wr       = 1'b1;
    pktin_data_valid_wr = vwr;
    pktin_data_valid    = v;
    tick();
    pktin_data_wr       = 1'b0;
    pktin_data_valid_wr = 1'b0;
  endtask

  task automatic send_meta(input logic [47:0] ts, input logic [31:0] seq);
    drive_line(2'b01, 4'd0, {ts, seq, 16'h00AB, 32'hDEAD_BEEF}, 1'b0, 1'b0);
  endtask

  // meta line + n payload lines; valid arrives vdelay cycles after the tail
  task automatic send_pkt(input logic [47:0] ts, input logic [31:0] seq, input int n,
                          input logic [3:0] bc, input logic v, input int vdelay);
    logic [127:0] d;
    logic [1:0]   fo;
    logic [3:0]   b;
    vexp_t        ve;
    bit           runt;
    runt = (n < MIN_LINES);
    send_meta(ts, seq);
    for (int i = 0; i < n; i++) begin
      d  = rnd128();
      b  = (i == n - 1) ? bc : 4'd0;
      fo = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
      if (!runt) exp_lines.push_back({fo, b, d});
      if (i == n - 1) drive_line(2'b10, b, d, vdelay == 0, v);
      else            drive_line(2'b11, b, d, 1'b0, 1'b0);
    end
    if (!runt) begin
      ve = {v, v, ts, seq};
      exp_valids.push_back(ve);
    end
    if (vdelay > 0) begin
      idle(vdelay - 1);
      pktin_data_valid_wr = 1'b1;
      pktin_data_valid    = v;
      tick();
      pktin_data_valid_wr = 1'b0;
    end
  endtask

  task automatic chk_counts(input string tag, input logic [31:0] p, input logic [15:0] r,
                            input logic [15:0] e, input logic [31:0] g);
    chk32({tag, ".pkt_num"},  pkt_num, p);
    chk32({tag, ".runt_num"}, {16'd0, runt_num}, {16'd0, r});
    chk32({tag, ".err_num"},  {16'd0, err_num},  {16'd0, e});
    chk32({tag, ".gap_num"},  gap_num, g);
  endtask

  always @(negedge clk) begin
    if (pktout_data_wr === 1'b1) begin
      if (exp_lines.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_line: got %h, expected no line", pktout_data);
      end else begin
        mon_line = exp_lines.pop_front();
        chk("out_line", pktout_data, mon_line);
      end
      if (pktout_data[133:132] == 2'b10) tails_seen++;
    end
    if (pktout_data_valid_wr === 1'b1) begin
      chk32("valid_after_tail", {31'd0, tails_seen > valids_seen}, 32'd1);
      valids_seen++;
      if (exp_valids.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got valid_wr=1, expected none");
      end else begin
        mon_v = exp_valids.pop_front();
        chk32("out_valid", {31'd0, pktout_data_valid}, {31'd0, mon_v.valid});
        chk32("meta_wr", {31'd0, meta_wr}, {31'd0, mon_v.mwr});
        if (mon_v.mwr) begin
          chk("meta_ts", {86'd0, meta_ts}, {86'd0, mon_v.ts});
          chk32("meta_seq", meta_seq, mon_v.seq);
        end
      end
    end
  end

  initial begin
    logic [127:0] d1, d2;
    vexp_t        ve;

    tbl[0] = '{32'd5,          4, 4'd6,  1'b1, 2, 32'd1, 16'd0, 32'd0};
    tbl[1] = '{32'd77,         1, 4'd0,  1'b1, 1, 32'd1, 16'd1, 32'd0};
    tbl[2] = '{32'd6,          2, 4'd3,  1'b1, 0, 32'd2, 16'd1, 32'd0};
    tbl[3] = '{32'd9,          3, 4'd15, 1'b1, 3, 32'd3, 16'd1, 32'd2};
    tbl[4] = '{32'd100,        3, 4'd1,  1'b0, 1, 32'd3, 16'd1, 32'd2};
    tbl[5] = '{32'hFFFF_FFFF,  2, 4'd2,  1'b1, 1, 32'd4, 16'd1, 32'hFFFF_FFF7};
    tbl[6] = '{32'd0,          5, 4'd4,  1'b1, 0, 32'd5, 16'd1, 32'hFFFF_FFF7};
    tbl[7] = '{32'd20,         2, 4'd0,  1'b1, 2, 32'd6, 16'd1, 32'hFFFF_FFFF};
    tbl[8] = '{32'd3,          2, 4'd9,  1'b1, 1, 32'd7, 16'd1, 32'hFFFF_FFFF};

    rst = 1'b1;
    cnt_rst = 1'b0;
    pktin_data = '0;
    pktin_data_wr = 1'b0;
    pktin_data_valid = 1'b0;
    pktin_data_valid_wr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst.pktout_data", pktout_data, '0);
    chk32("rst.strobes", {28'd0, pktout_data_wr, pktout_data_valid_wr, pktout_data_valid, meta_wr}, 32'd0);
    chk("rst.meta_ts", {86'd0, meta_ts}, '0);
    chk32("rst.meta_seq", meta_seq, 32'd0);
    chk_counts("rst", 32'd0, 16'd0, 16'd0, 32'd0);

    for (int i = 0; i < 9; i++) begin
      send_pkt(48'h1234_0000_0000 | 48'(i), tbl[i].seq, tbl[i].n, tbl[i].bc, tbl[i].v, tbl[i].vdelay);
      idle(6);
      chk_counts($sformatf("vec%0d", i), tbl[i].e_pkt, tbl[i].e_runt, 16'd0, tbl[i].e_gap);
    end

    // missing tail: meta + 2 lines, then the next packet's head
    send_meta(48'hAAAA_0000_0001, 32'd500);
    d1 = rnd128();
    d2 = rnd128();
    exp_lines.push_back({2'b01, 4'd0, d1});
    exp_lines.push_back({2'b10, 4'd5, d2});
    ve = {1'b0, 1'b0, 48'd0, 32'd0};
    exp_valids.push_back(ve);
    drive_line(2'b11, 4'd0, d1, 1'b0, 1'b0);
    drive_line(2'b11, 4'd5, d2, 1'b0, 1'b0);
    send_pkt(48'hAAAA_0000_0002, 32'd4, 3, 4'd2, 1'b1, 1);
    idle(6);
    chk_counts("abort", 32'd8, 16'd1, 16'd1, 32'hFFFF_FFFF);

    // counter clear in the cycle the good packet's valid is applied
    send_pkt(48'hBBBB_0000_0001, 32'd50, 2, 4'd1, 1'b1, 0);
    cnt_rst = 1'b1;
    tick();
    cnt_rst = 1'b0;
    idle(5);
    chk_counts("cnt_rst", 32'd0, 16'd0, 16'd0, 32'd0);
    send_pkt(48'hBBBB_0000_0002, 32'd53, 2, 4'd1, 1'b1, 1);
    idle(6);
    chk_counts("after_clr", 32'd1, 16'd0, 16'd0, 32'd2);

    // back-to-back: valid in the tail cycle, next head right after
    for (int k = 0; k < 3; k++)
      send_pkt(48'hCCCC_0000_0000 | 48'(k), 32'd54 + 32'(k), 2 + k, 4'(k + 7), 1'b1, 0);
    idle(8);
    chk_counts("b2b", 32'd4, 16'd0, 16'd0, 32'd2);

    // reset while a line sits in the hold register
    send_meta(48'hDDDD_0000_0001, 32'd900);
    drive_line(2'b11, 4'd0, rnd128(), 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(4);
    chk_counts("mid_rst", 32'd0, 16'd0, 16'd0, 32'd0);
    drive_line(2'b10, 4'd0, rnd128(), 1'b0, 1'b0);
    idle(2);
    chk32("stray_tail.err_num", {16'd0, err_num}, 32'd1);
    send_pkt(48'hEEEE_0000_0001, 32'd1000, 2, 4'd0, 1'b1, 1);
    idle(6);
    send_pkt(48'hEEEE_0000_0002, 32'd1002, 3, 4'd8, 1'b1, 2);
    idle(6);
    chk_counts("post_rst", 32'd2, 16'd0, 16'd1, 32'd1);

    idle(10);
    chk32("lines_drained", 32'(exp_lines.size()), 32'd0);
    chk32("valids_drained", 32'(exp_valids.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
